// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART family (tx now, rx later).
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int MIN_DIV    = 2;
  // Callers zero-extend their word to this width; zero padding does not affect the XOR.
  localparam int PAR_DATA_W = 16;

  function automatic logic calc_parity(input logic [PAR_DATA_W-1:0] data, input parity_t mode);
    case (mode)
      PAR_ODD:  return ~^data;
      PAR_EVEN: return ^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO; full is registered from the next level
// so it rises on the same edge that stores the last free entry.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LB   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LB:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LB-1:0]    wr_ptr, rd_ptr;
  logic [LB:0]      level_nxt;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (do_push && !do_pop)
      level_nxt = level + (LB+1)'(1);
    else if (!do_push && do_pop)
      level_nxt = level - (LB+1)'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + LB'(1);
      if (do_pop)  rd_ptr <= rd_ptr + LB'(1);
      level <= level_nxt;
      full  <= (level_nxt == (LB+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: FIFO-buffered, programmable divisor,
// optional parity, 1/2 stop bits; frame config is latched when a word is popped.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int DIV_WIDTH      = 16,
  localparam int LB_FIFO_DEPTH = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DATA_WIDTH-1:0]  data_from_sensor,
  input  logic                   valid_from_sensor,
  output logic                   ready_to_sensor,
  input  logic [DIV_WIDTH-1:0]   baud_div,
  input  logic [1:0]             parity_mode,
  input  logic                   two_stop,
  output logic                   tx_sig,
  output logic                   busy,
  output logic                   frame_done,
  output logic [LB_FIFO_DEPTH:0] fifo_level
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  logic                  push, pop, load, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  tx_state_t             state, state_nxt;
  parity_t               mode_in;
  logic [DIV_WIDTH-1:0]  cnt, cnt_nxt, div_q, div_nxt, start_div;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]      bit_idx, bit_nxt;
  logic                  par_en, par_en_nxt, par_bit, par_bit_nxt;
  logic                  two_q, two_nxt, stop2, stop2_nxt;
  logic                  tx_q, tx_nxt, done_q, done_nxt;

  uart_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .wdata (data_from_sensor),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign ready_to_sensor = ~fifo_full;
  assign push            = valid_from_sensor && ready_to_sensor;
  assign mode_in         = (parity_mode == 2'd3) ? PAR_NONE : parity_t'(parity_mode);
  assign start_div       = (baud_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : baud_div;

  assign tx_sig     = tx_q;
  assign frame_done = done_q;
  assign busy       = (state != IDLE) || (fifo_level != '0);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    div_nxt     = div_q;
    shreg_nxt   = shreg;
    bit_nxt     = bit_idx;
    par_en_nxt  = par_en;
    par_bit_nxt = par_bit;
    two_nxt     = two_q;
    stop2_nxt   = stop2;
    tx_nxt      = tx_q;
    done_nxt    = 1'b0;
    pop         = 1'b0;
    load        = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        load   = !fifo_empty;
      end
      START: begin
        if (cnt == '0) begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
          bit_nxt   = '0;
          cnt_nxt   = div_q - DIV_WIDTH'(1);
        end else cnt_nxt = cnt - DIV_WIDTH'(1);
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_nxt = div_q - DIV_WIDTH'(1);
          if (bit_idx == BIT_W'(DATA_WIDTH-1)) begin
            stop2_nxt = 1'b0;
            state_nxt = par_en ? PARITY : STOP;
            tx_nxt    = par_en ? par_bit : 1'b1;
          end else begin
            // Shift so the next bit to send always sits at shreg[1] -> shreg[0].
            bit_nxt   = bit_idx + BIT_W'(1);
            shreg_nxt = shreg >> 1;
            tx_nxt    = shreg[1];
          end
        end else cnt_nxt = cnt - DIV_WIDTH'(1);
      end
      PARITY: begin
        if (cnt == '0) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
          stop2_nxt = 1'b0;
          cnt_nxt   = div_q - DIV_WIDTH'(1);
        end else cnt_nxt = cnt - DIV_WIDTH'(1);
      end
      STOP: begin
        if (cnt == '0) begin
          if (two_q && !stop2) begin
            stop2_nxt = 1'b1;
            cnt_nxt   = div_q - DIV_WIDTH'(1);
          end else begin
            done_nxt = 1'b1;
            if (!fifo_empty) load = 1'b1;
            else begin
              state_nxt = IDLE;
              tx_nxt    = 1'b1;
            end
          end
        end else cnt_nxt = cnt - DIV_WIDTH'(1);
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
    // Frame start: shared by IDLE and the zero-gap STOP exit.
    if (load) begin
      pop         = 1'b1;
      state_nxt   = START;
      tx_nxt      = 1'b0;
      shreg_nxt   = fifo_rdata;
      div_nxt     = start_div;
      cnt_nxt     = start_div - DIV_WIDTH'(1);
      par_en_nxt  = (mode_in != PAR_NONE);
      par_bit_nxt = calc_parity(PAR_DATA_W'(fifo_rdata), mode_in);
      two_nxt     = two_stop;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      two_q   <= 1'b0;
      stop2   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      div_q   <= div_nxt;
      shreg   <= shreg_nxt;
      bit_idx <= bit_nxt;
      par_en  <= par_en_nxt;
      par_bit <= par_bit_nxt;
      two_q   <= two_nxt;
      stop2   <= stop2_nxt;
      tx_q    <= tx_nxt;
      done_q  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized bench for uart_tx_cfg against a frame-level reference model
// (word queue + per-frame bit timeline computed from divisor/parity/stop rules).
module tb_uart_tx_cfg;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 16;
  localparam int DMASK = (1 << DW) - 1;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [DW-1:0]   data_from_sensor = '0;
  logic            valid_from_sensor = 1'b0;
  logic            ready_to_sensor;
  logic [DIVW-1:0] baud_div = 16'd4;
  logic [1:0]      parity_mode = 2'd0;
  logic            two_stop = 1'b0;
  logic            tx_sig, busy, frame_done;
  logic [2:0]      fifo_level;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .data_from_sensor  (data_from_sensor),
    .valid_from_sensor (valid_from_sensor),
    .ready_to_sensor   (ready_to_sensor),
    .baud_div          (baud_div),
    .parity_mode       (parity_mode),
    .two_stop          (two_stop),
    .tx_sig            (tx_sig),
    .busy              (busy),
    .frame_done        (frame_done),
    .fifo_level        (fifo_level)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state (edge-indexed)
  int q[$];
  int e, cs, ce, fw, fdiv, fpm, ftwo;
  bit have, done_m, tx_m;
  int txlog[8192];
  int done_e[$];

  function automatic int frame_len(int div, int pm, int two);
    return div * (1 + DW + ((pm == 1 || pm == 2) ? 1 : 0) + (two ? 2 : 1));
  endfunction

  // Line level c clocks into a frame, from the bit sequence start/data/parity/stop.
  function automatic bit exp_bit(int w, int div, int pm, int two, int c);
    int idx, ones;
    idx  = c / div;
    ones = $countones(w & DMASK);
    if (idx == 0) return 1'b0;
    if (idx <= DW) return bit'((w >> (idx - 1)) & 1);
    if ((pm == 1 || pm == 2) && idx == DW + 1)
      return (pm == 2) ? bit'(ones % 2) : bit'(1 - ones % 2);
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    done_e.delete();
    e = 0; cs = 0; ce = 0; have = 0; done_m = 0; tx_m = 1;
  endtask

  // One clock: drive at negedge, step the model at posedge, compare at next negedge.
  task automatic cycle(input bit v, input int d);
    bit acc;
    logic [31:0] got, exp;
    valid_from_sensor = v;
    data_from_sensor  = DW'(d);
    acc = v && (q.size() != DEPTH);
    @(posedge clk);
    e++;
    done_m = have && (e == ce);
    if (e >= ce && q.size() > 0) begin
      fw   = q.pop_front();
      fdiv = (baud_div < 2) ? 2 : int'(baud_div);
      fpm  = int'(parity_mode);
      ftwo = int'(two_stop);
      cs   = e;
      ce   = e + frame_len(fdiv, fpm, ftwo);
      have = 1;
    end
    if (acc) q.push_back(d & DMASK);
    tx_m = (e < ce) ? exp_bit(fw, fdiv, fpm, ftwo, e - cs) : 1'b1;
    @(negedge clk);
    txlog[e % 8192] = int'(tx_sig);
    if (frame_done === 1'b1) done_e.push_back(e);
    got = {25'd0, tx_sig, frame_done, ready_to_sensor, busy, fifo_level};
    exp = {25'd0, tx_m, done_m, q.size() != DEPTH, (e < ce) || (q.size() != 0), 3'(q.size())};
    chk($sformatf("cyc%0d{tx,done,rdy,busy,lvl}", e), got, exp);
  endtask

  function automatic int tl(int idx);
    return txlog[idx % 8192];
  endfunction

  task automatic done_at(input string tag, input int idx, input int exp_e);
    if (idx < done_e.size()) chk(tag, done_e[idx], exp_e);
    else chk(tag, 32'hFFFF_FFFF, exp_e);
  endtask

  initial begin
    int k, nacc;
    bit saw_full;

    repeat (3) @(negedge clk);
    chk("rst_tx", tx_sig, 1);
    chk("rst_ready", ready_to_sensor, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_level", fifo_level, 0);
    rstn = 1'b1;
    model_reset();

    // Basic 8N1, divisor 4
    repeat (2) cycle(0, 0);
    cycle(1, 'hA5); k = e;
    repeat (44) cycle(0, 0);
    chk("8n1_start_first", tl(k + 1), 0);
    chk("8n1_start_last", tl(k + 4), 0);
    chk("8n1_bit0", tl(k + 5), 1);
    chk("8n1_bit1", tl(k + 9), 0);
    chk("8n1_stop", tl(k + 40), 1);
    done_at("8n1_done_edge", 0, k + 41);
    chk("8n1_ndone", done_e.size(), 1);

    // Even parity, two stop bits, divisor 3
    baud_div = 3; parity_mode = 2; two_stop = 1; done_e.delete();
    cycle(1, 'h07); k = e;
    repeat (40) cycle(0, 0);
    chk("e2_parity", tl(k + 1 + 28), 1);
    chk("e2_stop_end", tl(k + 1 + 35), 1);
    done_at("e2_len36", 0, k + 37);

    // Odd parity on zero data, divisor 2
    baud_div = 2; parity_mode = 1; two_stop = 0; done_e.delete();
    cycle(1, 'h00); k = e;
    repeat (26) cycle(0, 0);
    chk("odd_parity", tl(k + 1 + 18), 1);
    done_at("odd_len22", 0, k + 23);

    // Divisor clamp: 0 and 1 both behave as 2
    baud_div = 0; parity_mode = 0; done_e.delete();
    cycle(1, 'h5A); k = e;
    repeat (24) cycle(0, 0);
    done_at("clamp0_len20", 0, k + 21);
    baud_div = 1; done_e.delete();
    cycle(1, 'hC3); k = e;
    repeat (24) cycle(0, 0);
    done_at("clamp1_len20", 0, k + 21);

    // Back-to-back with backpressure: 5 words while valid is held
    baud_div = 2; done_e.delete(); nacc = 0; saw_full = 0; k = 0;
    for (int i = 0; i < 20 && nacc < 5; i++) begin
      bit a;
      a = (q.size() != DEPTH);
      cycle(1, 'h30 + nacc);
      if (i == 0) k = e;
      if (a) nacc++;
      if (fifo_level == 3'd4 && !ready_to_sensor) saw_full = 1;
    end
    chk("b2b_accepted", nacc, 5);
    chk("b2b_full_seen", saw_full, 1);
    repeat (110) cycle(0, 0);
    chk("b2b_ndone", done_e.size(), 5);
    for (int j = 0; j < 5; j++) done_at($sformatf("b2b_done%0d", j), j, k + 1 + 20 * (j + 1));
    chk("b2b_busy_end", busy, 0);

    // Mid-frame parity change: current frame unaffected, next gets parity
    parity_mode = 0; done_e.delete();
    cycle(1, 'h3C); k = e;
    cycle(1, 'h11);
    repeat (6) cycle(0, 0);
    parity_mode = 2;
    repeat (50) cycle(0, 0);
    done_at("cfg_f1_len20", 0, k + 21);
    done_at("cfg_f2_len22", 1, k + 43);

    // Reset in the middle of a frame
    baud_div = 4; parity_mode = 0; done_e.delete();
    cycle(1, 'h96);
    repeat (15) cycle(0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_tx", tx_sig, 1);
    chk("mrst_ready", ready_to_sensor, 1);
    chk("mrst_level", fifo_level, 0);
    chk("mrst_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("mrst_no_done", frame_done, 0);
      chk("mrst_tx_hold", tx_sig, 1);
    end
    rstn = 1'b1;
    model_reset();

    // Random traffic and config churn
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        baud_div    = DIVW'($urandom_range(0, 5));
        parity_mode = 2'($urandom_range(0, 3));
        two_stop    = 1'($urandom_range(0, 1));
      end
      cycle($urandom_range(0, 3) == 0, int'($urandom));
    end
    repeat (400) cycle(0, 0);
    chk("rand_idle_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
